// File: rtl/m_pkg.sv
// Shared definitions for the M-extension multiply controller: funct3 codes,
// FSM state encoding, operand sign pairs and small decode helpers.
package m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Sign pair: bit 1 = rs1 signed, bit 0 = rs2 signed
  localparam logic [1:0] SIGN_SS = 2'b11;
  localparam logic [1:0] SIGN_SU = 2'b10;
  localparam logic [1:0] SIGN_UU = 2'b00;

  // S_HIT is only reachable when the result cache is built in
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_HIT  = 2'd3
  } state_e;

  function automatic logic [1:0] sign_of(input logic [2:0] f3);
    case (f3)
      F3_MULHSU: return SIGN_SU;
      F3_MULHU:  return SIGN_UU;
      default:   return SIGN_SS;
    endcase
  endfunction

  function automatic logic [31:0] result_sel(input logic [2:0] f3, input logic [63:0] p);
    return (f3 == F3_MUL) ? p[31:0] : p[63:32];
  endfunction

endpackage

// File: rtl/m_mul_ctrl_if.sv
// Multiplier-side bundle of m_mul_ctrl: the controller is the master,
// the attached multiplier is the slave.
interface m_mul_ctrl_if;
  logic        mul_begin;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [1:0]  sign;
  logic [63:0] product;
  logic        mul_end;

  modport master (output mul_begin, op1, op2, sign, input product, mul_end);
  modport slave  (input mul_begin, op1, op2, sign, output product, mul_end);
endinterface

// File: rtl/m_mul_cache.sv
// Single-entry last-product cache for m_mul_ctrl: stores the 64-bit product
// with its {rs1, rs2, sign} tag; hit compares the lookup tag combinationally.
module m_mul_cache
  import m_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_clear_1,
  input  logic [31:0] i_rs1_32,
  input  logic [31:0] i_rs2_32,
  input  logic [1:0]  i_sign_2,
  input  logic        i_wr_1,
  input  logic [31:0] i_wrRs1_32,
  input  logic [31:0] i_wrRs2_32,
  input  logic [1:0]  i_wrSign_2,
  input  logic [63:0] i_wrProduct_64,
  output logic        o_hit_1,
  output logic [63:0] o_product_64
);

  logic        valid_q;
  logic [65:0] tag_q;
  logic [63:0] prod_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      prod_q  <= '0;
    end else if (i_clear_1) begin
      valid_q <= 1'b0;
    end else if (i_wr_1) begin
      valid_q <= 1'b1;
      tag_q   <= {i_wrRs1_32, i_wrRs2_32, i_wrSign_2};
      prod_q  <= i_wrProduct_64;
    end
  end

  assign o_hit_1      = valid_q && (tag_q == {i_rs1_32, i_rs2_32, i_sign_2});
  assign o_product_64 = prod_q;

endmodule

// File: rtl/m_mul_ctrl.sv
// EX-stage controller sequencing one M-extension multiply through an external
// multiplier. Optional single-entry result cache: define M_RESULT_CACHE_EN.
module m_mul_ctrl
  import m_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid_1,
  input  logic [2:0]  i_funct3_3,
  input  logic [31:0] i_rs1_32,
  input  logic [31:0] i_rs2_32,
  input  logic        i_flush_1,
  output logic        o_ready_1,
  output logic        o_stall_1,
  output logic [31:0] o_result_32,
  output logic        o_resultValid_1,
  output logic        o_mulBegin_1,
  output logic [31:0] o_mulOperand1_32,
  output logic [31:0] o_mulOperand2_32,
  output logic [1:0]  o_mulDivSign_2,
  input  logic [63:0] i_product_64,
  input  logic        i_mulEnd_1,
  output state_e      o_dbgState_2
);

  // Handshake: a request transfers on a rising edge where i_valid_1 and
  // o_ready_1 are both high, funct3[2] is clear and no flush is pending;
  // the result transfers on the single cycle o_resultValid_1 is high.

  state_e      state_q;
  logic [31:0] rs1_q, rs2_q, result_q;
  logic [2:0]  funct3_q;
  logic [1:0]  sign_q;
  logic        first_q, valid_q;
  logic        accept, mul_done;

  assign accept   = rstn && (state_q == S_IDLE) && i_valid_1 && !i_funct3_3[2] && !i_flush_1;
  // The multiplier may still show a stale end strobe in the first BUSY cycle
  assign mul_done = (state_q == S_BUSY) && !first_q && i_mulEnd_1;

`ifdef M_RESULT_CACHE_EN
  logic        cache_hit;
  logic [63:0] cache_prod;

  m_mul_cache u_cache (
    .clk            (clk),
    .rstn           (rstn),
    .i_clear_1      (i_flush_1),
    .i_rs1_32       (i_rs1_32),
    .i_rs2_32       (i_rs2_32),
    .i_sign_2       (sign_of(i_funct3_3)),
    .i_wr_1         (mul_done && !i_flush_1),
    .i_wrRs1_32     (rs1_q),
    .i_wrRs2_32     (rs2_q),
    .i_wrSign_2     (sign_q),
    .i_wrProduct_64 (i_product_64),
    .o_hit_1        (cache_hit),
    .o_product_64   (cache_prod)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      sign_q   <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (i_flush_1) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              rs1_q    <= i_rs1_32;
              rs2_q    <= i_rs2_32;
              funct3_q <= i_funct3_3;
              sign_q   <= sign_of(i_funct3_3);
              first_q  <= 1'b1;
`ifdef M_RESULT_CACHE_EN
              state_q  <= cache_hit ? S_HIT : S_BUSY;
`else
              state_q  <= S_BUSY;
`endif
            end
          end
          S_BUSY: begin
            first_q <= 1'b0;
            if (mul_done) begin
              result_q <= result_sel(funct3_q, i_product_64);
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end
          end
`ifdef M_RESULT_CACHE_EN
          S_HIT: begin
            result_q <= result_sel(funct3_q, cache_prod);
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ready_1        = (state_q == S_IDLE);
  assign o_stall_1        = accept || (state_q == S_BUSY) || (state_q == S_HIT);
  assign o_result_32      = result_q;
  assign o_resultValid_1  = valid_q && !i_flush_1;
  assign o_mulBegin_1     = (state_q == S_BUSY);
  assign o_mulOperand1_32 = rs1_q;
  assign o_mulOperand2_32 = rs2_q;
  assign o_mulDivSign_2   = sign_q;
  assign o_dbgState_2     = state_q;

endmodule

// File: tb/tb_m_mul_ctrl.sv
// Self-checking bench for m_mul_ctrl with a behavioural 8-cycle multiplier;
// expected results come from an arithmetic reference model and expected queue.
module tb_m_mul_ctrl;
  import m_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid_1, i_flush_1;
  logic [2:0]  i_funct3_3;
  logic [31:0] i_rs1_32, i_rs2_32;
  logic        o_ready_1, o_stall_1, o_resultValid_1;
  logic [31:0] o_result_32;
  state_e      o_dbgState_2;

  m_mul_ctrl_if mif ();

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // reference-model cache view: last completed multiply
  bit          c_valid = 1'b0;
  logic [31:0] c_a, c_b;
  logic [1:0]  c_s;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  m_mul_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_valid_1        (i_valid_1),
    .i_funct3_3       (i_funct3_3),
    .i_rs1_32         (i_rs1_32),
    .i_rs2_32         (i_rs2_32),
    .i_flush_1        (i_flush_1),
    .o_ready_1        (o_ready_1),
    .o_stall_1        (o_stall_1),
    .o_result_32      (o_result_32),
    .o_resultValid_1  (o_resultValid_1),
    .o_mulBegin_1     (mif.mul_begin),
    .o_mulOperand1_32 (mif.op1),
    .o_mulOperand2_32 (mif.op2),
    .o_mulDivSign_2   (mif.sign),
    .i_product_64     (mif.product),
    .i_mulEnd_1       (mif.mul_end),
    .o_dbgState_2     (o_dbgState_2)
  );

  // ---------------- behavioural multiplier (end strobe 8 cycles after begin) ----------------
  int mcnt = 0;
  logic [63:0] xa, xb;
  always @(posedge clk) mcnt <= mif.mul_begin ? mcnt + 1 : 0;
  assign xa          = mif.sign[1] ? {{32{mif.op1[31]}}, mif.op1} : {32'h0, mif.op1};
  assign xb          = mif.sign[0] ? {{32{mif.op2[31]}}, mif.op2} : {32'h0, mif.op2};
  assign mif.product = xa * xb;
  assign mif.mul_end = mif.mul_begin && (mcnt == 8);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      default:    p = 64'(ua * ub);
    endcase
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [1:0] ref_sign(input logic [2:0] f3);
    case (f3)
      3'd2:    return 2'b10;
      3'd3:    return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rstn && o_resultValid_1) begin
      if (exp_q.size() == 0) chk("spurious_valid", 64'(o_resultValid_1), 64'd0);
      else                   chk("result", 64'(o_result_32), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output logic [31:0] res);
    int n, begins;
    bit hit;
    logic [1:0] sc;
    sc  = ref_sign(f3);
    hit = 1'b0;
`ifdef M_RESULT_CACHE_EN
    hit = c_valid && (c_a == a) && (c_b == b) && (c_s == sc);
`endif
    @(negedge clk);
    i_valid_1 = 1'b1; i_funct3_3 = f3; i_rs1_32 = a; i_rs2_32 = b;
    #1;
    chk("ready_idle", 64'(o_ready_1), 64'd1);
    chk("stall_accept", 64'(o_stall_1), 64'd1);
    exp_q.push_back(ref_mul(f3, a, b));
    @(negedge clk);
    if (hold) begin i_rs1_32 = $urandom; i_rs2_32 = $urandom; end
    else i_valid_1 = 1'b0;
    chk("operand1", 64'(mif.op1), 64'(a));
    chk("operand2", 64'(mif.op2), 64'(b));
    chk("sign", 64'(mif.sign), 64'(sc));
    n = 1; begins = 0;
    while (!o_resultValid_1 && n < 40) begin
      if (mif.mul_begin) begins++;
      if (n == 2) chk("ready_busy", 64'(o_ready_1), 64'd0);
      if (n == 3) chk("operand1_hold", 64'(mif.op1), 64'(a));
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 64'(o_resultValid_1), 64'd1);
    chk("latency", 64'(n), hit ? 64'd2 : 64'd10);
    chk("begin_cycles", 64'(begins), hit ? 64'd0 : 64'd9);
    chk("ready_done", 64'(o_ready_1), 64'd0);
    chk("stall_done", 64'(o_stall_1), 64'd0);
    res = o_result_32;
    i_valid_1 = 1'b0;
    @(negedge clk);
    chk("valid_one_cycle", 64'(o_resultValid_1), 64'd0);
    chk("result_hold", 64'(o_result_32), 64'(res));
    c_valid = 1'b1; c_a = a; c_b = b; c_s = sc;
  endtask

  task automatic ignored_req(input logic [2:0] f3);
    @(negedge clk);
    i_valid_1 = 1'b1; i_funct3_3 = f3; i_rs1_32 = $urandom; i_rs2_32 = $urandom;
    #1;
    chk("ignored_stall", 64'(o_stall_1), 64'd0);
    @(negedge clk);
    i_valid_1 = 1'b0;
    chk("ignored_begin", 64'(mif.mul_begin), 64'd0);
    chk("ignored_ready", 64'(o_ready_1), 64'd1);
  endtask

  // ---------------- main stimulus ----------------
  logic [2:0]  d_f3 [7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0};
  logic [31:0] d_a  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd7};
  logic [31:0] d_b  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd9, 32'd9, 32'd9};
  logic [31:0] d_r  [7] = '{32'h1, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h3F};
  logic [31:0] pool [4] = '{32'd7, 32'd9, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    logic [31:0] res;
    logic [2:0]  f3;
    logic [31:0] a, b;
    rstn = 1'b0; i_valid_1 = 1'b0; i_flush_1 = 1'b0;
    i_funct3_3 = '0; i_rs1_32 = '0; i_rs2_32 = '0;
    repeat (3) @(negedge clk);
    chk("rst_begin", 64'(mif.mul_begin), 64'd0);
    chk("rst_result", 64'(o_result_32), 64'd0);
    chk("rst_valid", 64'(o_resultValid_1), 64'd0);
    chk("rst_stall", 64'(o_stall_1), 64'd0);
    chk("rst_op1", 64'(mif.op1), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(o_ready_1), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_req(d_f3[i], d_a[i], d_b[i], 1'b0, res);
      chk("directed", 64'(res), 64'(d_r[i]));
    end

    // valid held through BUSY with changing operands
    run_req(3'd3, 32'h0001_0000, 32'h0003_0000, 1'b1, res);
    chk("hold_result", 64'(res), 64'd3);

    ignored_req(3'd4);
    ignored_req(3'd7);

    // flush at T0+4 of a MULHU
    @(negedge clk);
    i_valid_1 = 1'b1; i_funct3_3 = 3'd3; i_rs1_32 = 32'h1234_5678; i_rs2_32 = 32'h9ABC_DEF0;
    @(negedge clk);
    i_valid_1 = 1'b0;
    repeat (3) @(negedge clk);
    i_flush_1 = 1'b1;
    @(negedge clk);
    i_flush_1 = 1'b0;
    c_valid = 1'b0;
    chk("flush_begin", 64'(mif.mul_begin), 64'd0);
    chk("flush_ready", 64'(o_ready_1), 64'd1);
    repeat (12) @(negedge clk);
    run_req(3'd0, 32'd5, 32'd6, 1'b0, res);
    chk("after_flush", 64'(res), 64'd30);

    // asynchronous reset at T0+3 mid-BUSY
    @(negedge clk);
    i_valid_1 = 1'b1; i_funct3_3 = 3'd1; i_rs1_32 = 32'hDEAD_BEEF; i_rs2_32 = 32'h1234;
    @(negedge clk);
    i_valid_1 = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    c_valid = 1'b0;
    chk("midrst_begin", 64'(mif.mul_begin), 64'd0);
    chk("midrst_result", 64'(o_result_32), 64'd0);
    chk("midrst_valid", 64'(o_resultValid_1), 64'd0);
    chk("midrst_stall", 64'(o_stall_1), 64'd0);
    chk("midrst_ops", {mif.op1, mif.op2}, 64'd0);
    chk("midrst_sign", 64'(mif.sign), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midrst_ready", 64'(o_ready_1), 64'd1);
    run_req(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, res);
    chk("after_reset", 64'(res), 64'hFFFF_FFFF);

    // randomized requests, operand pool biased to revisit tags
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 5));
      a  = ($urandom_range(0, 2) == 0) ? 32'($urandom) : pool[$urandom_range(0, 3)];
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom) : pool[$urandom_range(0, 3)];
      if (f3[2]) ignored_req(f3);
      else run_req(f3, a, b, 1'($urandom_range(0, 1)), res);
    end

    repeat (4) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
